// File: rtl/cpu_isa_pkg.sv
// rtl/cpu_isa_pkg.sv - ISA constants, field positions and sequencer states
package cpu_isa_pkg;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;

    localparam int OP_HI   = 31;
    localparam int OP_LO   = 24;
    localparam int DEST_HI = 18;
    localparam int DEST_LO = 16;
    localparam int SRC1_HI = 10;
    localparam int SRC1_LO = 8;
    localparam int SRC2_HI = 2;
    localparam int SRC2_LO = 0;
    localparam int IMM_HI  = 7;
    localparam int IMM_LO  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_OPWAIT,
        ST_WB,
        ST_NEXT
    } state_t;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational opcode to ALU select decode
module instr_decoder
    import cpu_isa_pkg::*;
(
    input  logic [7:0] op,
    output logic [2:0] aluop,
    output logic       imm_sel,
    output logic       neg_sel,
    output logic       legal
);

    // Map opcode to ALU function and operand-2 selects; unknown opcodes are flagged illegal
    always_comb begin
        aluop   = ALU_PASS;
        imm_sel = 1'b0;
        neg_sel = 1'b0;
        legal   = 1'b1;
        case (op)
            OP_LOADI: imm_sel = 1'b1;
            OP_MOV:   aluop   = ALU_PASS;
            OP_ADD:   aluop   = ALU_ADD;
            OP_SUB: begin
                aluop   = ALU_ADD;
                neg_sel = 1'b1;
            end
            OP_AND:   aluop   = ALU_AND;
            OP_OR:    aluop   = ALU_OR;
            default:  legal   = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle fetch/decode/writeback control sequencer
module instr_sequencer
    import cpu_isa_pkg::*;
#(
    parameter int READ_LAT = 1,
    parameter int ALU_LAT  = 1,
    parameter int PC_W     = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            RUN,
    output logic [PC_W-1:0] IMEM_ADDR,
    output logic            IMEM_REQ,
    input  logic            IMEM_ACK,
    input  logic [31:0]     INSTR,
    output logic [2:0]      OUT1ADDRESS,
    output logic [2:0]      OUT2ADDRESS,
    output logic [2:0]      INADDRESS,
    output logic            WRITE,
    output logic [2:0]      ALUOP,
    output logic [7:0]      IMMEDIATE,
    output logic            IMM_SEL,
    output logic            NEG_SEL,
    output logic            ILLEGAL,
    output logic            BUSY
);

    localparam int         LAT      = READ_LAT + ALU_LAT;
    localparam logic [7:0] CNT_INIT = 8'((LAT > 0) ? LAT - 1 : 0);

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc;
    logic [7:0]      op_q;
    logic [2:0]      dest_q, src1_q, src2_q;
    logic [7:0]      imm_q;
    logic [7:0]      cnt;
    logic [2:0]      dec_aluop;
    logic            dec_imm_sel, dec_neg_sel, dec_legal;
    logic            unused_instr_bits;

    // Reserved instruction bits carry no meaning for this ISA
    assign unused_instr_bits = ^{INSTR[23:19], INSTR[15:11]};

    instr_decoder u_decoder (
        .op      (op_q),
        .aluop   (dec_aluop),
        .imm_sel (dec_imm_sel),
        .neg_sel (dec_neg_sel),
        .legal   (dec_legal)
    );

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // PC, latched instruction fields and operand-wait down-counter
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc     <= '0;
            op_q   <= '0;
            dest_q <= '0;
            src1_q <= '0;
            src2_q <= '0;
            imm_q  <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                ST_FETCH: if (IMEM_ACK) begin
                    op_q   <= INSTR[OP_HI:OP_LO];
                    dest_q <= INSTR[DEST_HI:DEST_LO];
                    src1_q <= INSTR[SRC1_HI:SRC1_LO];
                    src2_q <= INSTR[SRC2_HI:SRC2_LO];
                    imm_q  <= INSTR[IMM_HI:IMM_LO];
                end
                ST_DECODE: cnt <= CNT_INIT;
                ST_OPWAIT: if (cnt != 8'd0) cnt <= cnt - 8'd1;
                ST_NEXT:   pc  <= pc + PC_W'(4);
                default: ;
            endcase
        end
    end

    assign IMEM_ADDR = pc;

    // Next-state logic and state-decoded outputs; decode outputs live from DECODE through WB
    always_comb begin
        state_nxt   = state;
        IMEM_REQ    = 1'b0;
        WRITE       = 1'b0;
        ILLEGAL     = 1'b0;
        BUSY        = (state != ST_IDLE);
        OUT1ADDRESS = '0;
        OUT2ADDRESS = '0;
        INADDRESS   = '0;
        ALUOP       = '0;
        IMMEDIATE   = '0;
        IMM_SEL     = 1'b0;
        NEG_SEL     = 1'b0;

        if (state == ST_DECODE || state == ST_OPWAIT || state == ST_WB) begin
            OUT1ADDRESS = src1_q;
            OUT2ADDRESS = src2_q;
            INADDRESS   = dest_q;
            ALUOP       = dec_aluop;
            IMMEDIATE   = imm_q;
            IMM_SEL     = dec_imm_sel;
            NEG_SEL     = dec_neg_sel;
        end

        case (state)
            ST_IDLE: if (RUN) state_nxt = ST_FETCH;
            ST_FETCH: begin
                IMEM_REQ = 1'b1;
                if (IMEM_ACK) state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                if (!dec_legal) begin
                    ILLEGAL   = 1'b1;
                    state_nxt = ST_NEXT;
                end else if (LAT == 0) begin
                    state_nxt = ST_WB;
                end else begin
                    state_nxt = ST_OPWAIT;
                end
            end
            ST_OPWAIT: if (cnt == 8'd0) state_nxt = ST_WB;
            ST_WB: begin
                WRITE     = 1'b1;
                state_nxt = ST_NEXT;
            end
            ST_NEXT: state_nxt = RUN ? ST_FETCH : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        RUN;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_REQ;
    logic        IMEM_ACK;
    logic [31:0] INSTR;
    logic [2:0]  OUT1ADDRESS, OUT2ADDRESS, INADDRESS, ALUOP;
    logic        WRITE, IMM_SEL, NEG_SEL, ILLEGAL, BUSY;
    logic [7:0]  IMMEDIATE;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int wr_cnt = 0;
    int req_cnt = 0;
    int n, c0, w0, r0;

    instr_sequencer #(.READ_LAT(1), .ALU_LAT(1), .PC_W(32)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .RUN         (RUN),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ACK    (IMEM_ACK),
        .INSTR       (INSTR),
        .OUT1ADDRESS (OUT1ADDRESS),
        .OUT2ADDRESS (OUT2ADDRESS),
        .INADDRESS   (INADDRESS),
        .WRITE       (WRITE),
        .ALUOP       (ALUOP),
        .IMMEDIATE   (IMMEDIATE),
        .IMM_SEL     (IMM_SEL),
        .NEG_SEL     (NEG_SEL),
        .ILLEGAL     (ILLEGAL),
        .BUSY        (BUSY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (WRITE)    wr_cnt++;
        if (IMEM_REQ) req_cnt++;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(output int cnt);
        cnt = 0;
        while (IMEM_REQ !== 1'b1 && cnt < 50) begin
            tick;
            cnt++;
        end
    endtask

    task automatic wait_write(output int cnt);
        cnt = 0;
        while (WRITE !== 1'b1 && cnt < 50) begin
            tick;
            cnt++;
        end
    endtask

    initial begin
        RESET = 1'b0; RUN = 1'b0; IMEM_ACK = 1'b0; INSTR = '0;
        tick; tick;
        check("rst_write", WRITE, 0);
        check("rst_busy", BUSY, 0);
        check("rst_req", IMEM_REQ, 0);
        check("rst_addr", IMEM_ADDR, 0);
        check("rst_illegal", ILLEGAL, 0);
        RESET = 1'b1;
        tick;
        check("idle_busy", BUSY, 0);

        // LOADI R2,#0x2A with immediate ACK
        RUN = 1'b1;
        tick;
        check("a_req", IMEM_REQ, 1);
        check("a_addr", IMEM_ADDR, 0);
        c0 = cyc; w0 = wr_cnt;
        INSTR = 32'h0002002A; IMEM_ACK = 1'b1;
        tick;
        IMEM_ACK = 1'b0;
        check("a_dec_req", IMEM_REQ, 0);
        check("a_dec_write", WRITE, 0);
        wait_write(n);
        check("a_to_wb", n, 3);
        check("a_wb_inaddr", INADDRESS, 2);
        check("a_wb_imm", IMMEDIATE, 8'h2A);
        check("a_wb_immsel", IMM_SEL, 1);
        check("a_wb_aluop", ALUOP, 0);
        tick;
        check("a_next_write", WRITE, 0);
        check("a_next_imm", IMMEDIATE, 0);
        wait_req(n);
        check("a_period", cyc - c0, 6);
        check("a_pc", IMEM_ADDR, 4);
        check("a_wr_pulses", wr_cnt - w0, 1);

        // SUB R4,R1,R2
        w0 = wr_cnt;
        INSTR = 32'h03040102; IMEM_ACK = 1'b1;
        tick;
        IMEM_ACK = 1'b0;
        check("b_out1", OUT1ADDRESS, 1);
        check("b_out2", OUT2ADDRESS, 2);
        check("b_aluop", ALUOP, 3'b001);
        check("b_neg", NEG_SEL, 1);
        check("b_inaddr", INADDRESS, 4);
        check("b_immsel", IMM_SEL, 0);
        wait_write(n);
        check("b_to_wb", n, 3);
        check("b_wb_neg", NEG_SEL, 1);
        tick;
        check("b_next_neg", NEG_SEL, 0);
        wait_req(n);
        check("b_wr_pulses", wr_cnt - w0, 1);
        check("b_pc", IMEM_ADDR, 8);

        // AND R5,R6,R7 with ACK delayed 3 cycles
        c0 = cyc;
        IMEM_ACK = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("c_req_hold", IMEM_REQ, 1);
            check("c_addr_hold", IMEM_ADDR, 8);
        end
        INSTR = 32'h04050607; IMEM_ACK = 1'b1;
        tick;
        IMEM_ACK = 1'b0;
        check("c_aluop", ALUOP, 3'b010);
        check("c_inaddr", INADDRESS, 5);
        wait_req(n);
        check("c_period", cyc - c0, 9);
        check("c_pc", IMEM_ADDR, 12);

        // Illegal opcode
        w0 = wr_cnt;
        INSTR = 32'hFF000000; IMEM_ACK = 1'b1;
        tick;
        IMEM_ACK = 1'b0;
        check("d_illegal", ILLEGAL, 1);
        check("d_write", WRITE, 0);
        tick;
        check("d_illegal_drop", ILLEGAL, 0);
        tick;
        check("d_req", IMEM_REQ, 1);
        check("d_pc", IMEM_ADDR, 16);
        check("d_no_write", wr_cnt - w0, 0);

        // ADD R3,R1,R2 with reset asserted during WB
        w0 = wr_cnt;
        INSTR = 32'h02030102; IMEM_ACK = 1'b1;
        tick;
        IMEM_ACK = 1'b0;
        wait_write(n);
        check("e_in_wb", WRITE, 1);
        #2 RESET = 1'b0;
        #1;
        check("e_async_write", WRITE, 0);
        check("e_async_busy", BUSY, 0);
        check("e_async_pc", IMEM_ADDR, 0);
        check("e_async_inaddr", INADDRESS, 0);
        tick;
        check("e_no_write", wr_cnt - w0, 0);
        RESET = 1'b1;
        tick;
        check("e_refetch_req", IMEM_REQ, 1);
        check("e_refetch_addr", IMEM_ADDR, 0);

        // OR R1,R2,R3 with RUN dropped in OPWAIT
        w0 = wr_cnt;
        INSTR = 32'h05010203; IMEM_ACK = 1'b1;
        tick;
        IMEM_ACK = 1'b0;
        check("f_aluop", ALUOP, 3'b011);
        tick;
        RUN = 1'b0;
        wait_write(n);
        check("f_to_wb", n, 2);
        tick;
        tick;
        check("f_idle_busy", BUSY, 0);
        check("f_idle_req", IMEM_REQ, 0);
        check("f_pc", IMEM_ADDR, 4);
        r0 = req_cnt;
        IMEM_ACK = 1'b1;
        for (int i = 0; i < 10; i++) tick;
        IMEM_ACK = 1'b0;
        check("f_no_req", req_cnt - r0, 0);
        check("f_ack_ignored", BUSY, 0);
        check("f_wr_pulses", wr_cnt - w0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
